// File: rtl/cook_timer_seq.sv
// Microwave cook-timer controller: BCD keypad/preset time entry, countdown with
// pause/resume and door interlock, power-level drive and a patterned end-of-cook buzzer.
module cook_timer_seq #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ADD_SEC     = 30,
    parameter int BEEP_CYCLES = 25_000_000,
    parameter int BEEP_COUNT  = 3,
    parameter int POWER_STEP  = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       preset_valid,
    input  logic [6:0] preset_min,
    input  logic [5:0] preset_sec,
    input  logic [3:0] power_level,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [7:0] power,
    output logic       running,
    output logic       paused,
    output logic       buzzer,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int CW = $clog2(BEEP_CYCLES + 1);
    localparam int NW = $clog2(BEEP_COUNT + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CYC_LAST  = CW'(BEEP_CYCLES - 1);
    localparam logic [NW-1:0] BEEP_LAST = NW'(BEEP_COUNT - 1);
    localparam logic [13:0]   MAX_SECS  = 14'd5999;
    localparam logic [13:0]   ADD_SECS  = 14'(ADD_SEC);
    localparam logic [7:0]    STEP8     = 8'(POWER_STEP);

    // Arithmetic is done on total seconds; the BCD digits are only the storage/display form.
    function automatic logic [13:0] to_secs(input logic [15:0] t);
        logic [13:0] mm;
        logic [13:0] ss;
        mm = 14'(t[15:12]) * 14'd10 + 14'(t[11:8]);
        ss = 14'(t[7:4]) * 14'd10 + 14'(t[3:0]);
        return mm * 14'd60 + ss;
    endfunction

    function automatic logic [13:0] sat_secs(input logic [13:0] s);
        return (s > MAX_SECS) ? MAX_SECS : s;
    endfunction

    function automatic logic [7:0] to_bcd2(input logic [6:0] v);
        logic [6:0] c;
        c = (v > 7'd99) ? 7'd99 : v;
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction

    function automatic logic [15:0] from_secs(input logic [13:0] s);
        logic [13:0] mm;
        logic [13:0] ss;
        mm = s / 14'd60;
        ss = s % 14'd60;
        return {to_bcd2(7'(mm)), to_bcd2(7'(ss))};
    endfunction

    function automatic logic [3:0] clamp_level(input logic [3:0] l);
        return (l > 4'd10) ? 4'd10 : l;
    endfunction

    logic [2:0]    state_r;
    logic [15:0]   time_r;
    logic [PW-1:0] presc_r;
    logic [3:0]    level_r;
    logic [CW-1:0] cyc_r;
    logic          beep_on_r;
    logic [NW-1:0] beeps_r;
    logic          start_d_r;
    logic          stop_d_r;
    logic          door_d_r;
    logic [7:0]    power_r;
    logic          running_r;
    logic          paused_r;
    logic          buzzer_r;

    logic [2:0]    state_nxt_s;
    logic [15:0]   time_nxt_s;
    logic [PW-1:0] presc_nxt_s;
    logic [3:0]    level_nxt_s;
    logic [CW-1:0] cyc_nxt_s;
    logic          beep_on_nxt_s;
    logic [NW-1:0] beeps_nxt_s;
    logic [7:0]    power_nxt_s;
    logic          buzzer_nxt_s;
    logic [13:0]   cur_secs_s;
    logic [13:0]   start_secs_s;
    logic [13:0]   cook_secs_s;
    logic          tick_s;
    logic          start_rise_s;
    logic          stop_rise_s;
    logic          door_rise_s;

    assign start_rise_s = start & ~start_d_r;
    assign stop_rise_s  = stop & ~stop_d_r;
    assign door_rise_s  = door_open & ~door_d_r;

    // Next-state decisions, evaluated in priority order door > stop > start > tick > entry
    always_comb begin
        state_nxt_s   = state_r;
        time_nxt_s    = time_r;
        presc_nxt_s   = presc_r;
        level_nxt_s   = level_r;
        cyc_nxt_s     = cyc_r;
        beep_on_nxt_s = beep_on_r;
        beeps_nxt_s   = beeps_r;
        cur_secs_s    = to_secs(time_r);
        start_secs_s  = (state_r == S_IDLE) ? sat_secs(ADD_SECS) : sat_secs(cur_secs_s);
        cook_secs_s   = cur_secs_s;
        tick_s        = (presc_r == PRE_LAST);

        case (state_r)
            S_IDLE, S_SET: begin
                if (stop_rise_s) begin
                    state_nxt_s = S_IDLE;
                    time_nxt_s  = 16'h0000;
                end else if (start_rise_s && !door_open &&
                             (state_r == S_SET || cur_secs_s == 14'd0)) begin
                    if (start_secs_s == 14'd0) begin
                        state_nxt_s = S_IDLE;
                        time_nxt_s  = 16'h0000;
                    end else begin
                        state_nxt_s = S_COOK;
                        time_nxt_s  = from_secs(start_secs_s);
                        presc_nxt_s = '0;
                        level_nxt_s = clamp_level(power_level);
                    end
                end else if (preset_valid) begin
                    state_nxt_s = S_SET;
                    time_nxt_s  = {to_bcd2(preset_min), to_bcd2({1'b0, preset_sec})};
                end else if (digit_valid && digit <= 4'd9) begin
                    state_nxt_s = S_SET;
                    time_nxt_s  = {time_r[11:0], digit};
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_COOK: begin
                if (door_open || stop_rise_s) begin
                    state_nxt_s = S_PAUSE;
                end else begin
                    presc_nxt_s = tick_s ? '0 : presc_r + PW'(1);
                    // A start edge on a tick cycle applies both: net +ADD_SEC-1
                    if (start_rise_s) begin
                        cook_secs_s = sat_secs(cur_secs_s + ADD_SECS - {13'd0, tick_s});
                    end else if (tick_s) begin
                        cook_secs_s = cur_secs_s - 14'd1;
                    end else begin
                        cook_secs_s = cur_secs_s;
                    end
                    time_nxt_s = from_secs(cook_secs_s);
                    if (cook_secs_s == 14'd0) begin
                        state_nxt_s   = S_DONE;
                        cyc_nxt_s     = '0;
                        beep_on_nxt_s = 1'b1;
                        beeps_nxt_s   = '0;
                    end else begin
                        state_nxt_s = S_COOK;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_rise_s) begin
                    state_nxt_s = S_IDLE;
                    time_nxt_s  = 16'h0000;
                end else if (start_rise_s && !door_open) begin
                    state_nxt_s = S_COOK;
                end else begin
                    state_nxt_s = S_PAUSE;
                end
            end
            S_DONE: begin
                time_nxt_s = 16'h0000;
                if (stop_rise_s || door_rise_s) begin
                    state_nxt_s   = S_IDLE;
                    beep_on_nxt_s = 1'b0;
                end else if (cyc_r != CYC_LAST) begin
                    cyc_nxt_s = cyc_r + CW'(1);
                end else begin
                    cyc_nxt_s = '0;
                    if (beep_on_r) begin
                        beep_on_nxt_s = 1'b0;
                    end else if (beeps_r == BEEP_LAST) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        beeps_nxt_s   = beeps_r + NW'(1);
                        beep_on_nxt_s = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                time_nxt_s  = 16'h0000;
            end
        endcase

        power_nxt_s  = (state_nxt_s == S_COOK) ? STEP8 * {4'd0, level_nxt_s} : 8'd0;
        buzzer_nxt_s = (state_nxt_s == S_DONE) & beep_on_nxt_s;
    end

    // State, counters, edge detectors and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            time_r    <= 16'h0000;
            presc_r   <= '0;
            level_r   <= 4'd0;
            cyc_r     <= '0;
            beep_on_r <= 1'b0;
            beeps_r   <= '0;
            start_d_r <= 1'b0;
            stop_d_r  <= 1'b0;
            door_d_r  <= 1'b0;
            power_r   <= 8'd0;
            running_r <= 1'b0;
            paused_r  <= 1'b0;
            buzzer_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            time_r    <= time_nxt_s;
            presc_r   <= presc_nxt_s;
            level_r   <= level_nxt_s;
            cyc_r     <= cyc_nxt_s;
            beep_on_r <= beep_on_nxt_s;
            beeps_r   <= beeps_nxt_s;
            start_d_r <= start;
            stop_d_r  <= stop;
            door_d_r  <= door_open;
            power_r   <= power_nxt_s;
            running_r <= (state_nxt_s == S_COOK);
            paused_r  <= (state_nxt_s == S_PAUSE);
            buzzer_r  <= buzzer_nxt_s;
        end
    end

    assign min_tens = time_r[15:12];
    assign min_ones = time_r[11:8];
    assign sec_tens = time_r[7:4];
    assign sec_ones = time_r[3:0];
    assign power    = power_r;
    assign running  = running_r;
    assign paused   = paused_r;
    assign buzzer   = buzzer_r;
    assign state    = state_r;

endmodule

// File: tb/tb_cook_timer_seq.sv
// Self-checking bench for cook_timer_seq: directed scenarios plus randomized traffic
// compared against a seconds-based behavioural model of the controller.
module tb_cook_timer_seq;

    localparam int TICK_DIV    = 4;
    localparam int ADD_SEC     = 30;
    localparam int BEEP_CYCLES = 2;
    localparam int BEEP_COUNT  = 3;
    localparam int POWER_STEP  = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       preset_valid = 1'b0;
    logic [6:0] preset_min = 7'd0;
    logic [5:0] preset_sec = 6'd0;
    logic [3:0] power_level = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [7:0] power;
    logic       running, paused, buzzer;
    logic [2:0] state;
    logic [29:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // model: remaining time as plain seconds, keypad entry as a 4-digit decimal number
    int m_st, m_secs, m_entry, m_el, m_dc, m_lvl;
    bit p_start, p_stop, p_door;

    cook_timer_seq #(
        .TICK_DIV(TICK_DIV), .ADD_SEC(ADD_SEC), .BEEP_CYCLES(BEEP_CYCLES),
        .BEEP_COUNT(BEEP_COUNT), .POWER_STEP(POWER_STEP)
    ) dut (
        .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
        .preset_valid(preset_valid), .preset_min(preset_min), .preset_sec(preset_sec),
        .power_level(power_level), .start(start), .stop(stop), .door_open(door_open),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .power(power), .running(running), .paused(paused), .buzzer(buzzer), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_vec = {state, min_tens, min_ones, sec_tens, sec_ones, power, running, paused, buzzer};

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_st = 0; m_secs = 0; m_entry = 0; m_el = 0; m_dc = 0; m_lvl = 0;
        p_start = 0; p_stop = 0; p_door = 0;
    endfunction

    function automatic void model_step();
        bit se, pe, de;
        int tk, s;
        se = start && !p_start;
        pe = stop && !p_stop;
        de = door_open && !p_door;
        if (m_st == 0 || m_st == 1) begin
            if (pe) begin
                m_st = 0; m_secs = 0;
            end else if (se && !door_open && (m_st == 1 || m_secs == 0)) begin
                s = (m_st == 0) ? imin(ADD_SEC, 5999)
                                : imin((m_entry / 100) * 60 + m_entry % 100, 5999);
                if (s == 0) begin
                    m_st = 0; m_secs = 0;
                end else begin
                    m_st = 2; m_secs = s; m_el = 0;
                    m_lvl = (int'(power_level) > 10) ? 10 : int'(power_level);
                end
            end else if (preset_valid) begin
                m_st = 1; m_entry = imin(int'(preset_min), 99) * 100 + int'(preset_sec);
            end else if (digit_valid && digit <= 4'd9) begin
                m_entry = ((m_st == 1) ? m_entry % 1000 : 0) * 10 + int'(digit);
                m_st = 1;
            end
        end else if (m_st == 2) begin
            if (door_open || pe) begin
                m_st = 3;
            end else begin
                m_el = m_el + 1;
                tk = (m_el % TICK_DIV == 0) ? 1 : 0;
                if (se) m_secs = imin(m_secs + ADD_SEC - tk, 5999);
                else m_secs = m_secs - tk;
                if (m_secs == 0) begin
                    m_st = 4; m_dc = 0;
                end
            end
        end else if (m_st == 3) begin
            if (pe) begin
                m_st = 0; m_secs = 0;
            end else if (se && !door_open) begin
                m_st = 2;
            end
        end else begin
            if (pe || de) begin
                m_st = 0;
            end else begin
                m_dc = m_dc + 1;
                if (m_dc >= 2 * BEEP_CYCLES * BEEP_COUNT) m_st = 0;
            end
        end
        p_start = start; p_stop = stop; p_door = door_open;
    endfunction

    function automatic logic [29:0] exp_vec();
        int mm, ss;
        logic [15:0] t;
        logic bz;
        if (m_st == 1) begin
            t = {4'(m_entry / 1000), 4'((m_entry / 100) % 10), 4'((m_entry / 10) % 10), 4'(m_entry % 10)};
        end else begin
            mm = m_secs / 60; ss = m_secs % 60;
            t = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        end
        bz = (m_st == 4) && ((m_dc % (2 * BEEP_CYCLES)) < BEEP_CYCLES);
        return {3'(m_st), t, 8'((m_st == 2) ? m_lvl * POWER_STEP : 0), m_st == 2, m_st == 3, bz};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int d);
        digit_valid = 1'b1; digit = 4'(d);
        step();
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== 19'd0) begin
            $display("FAIL reset_state_time got %h expected 0", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        checks++;
        if ({power, running, paused, buzzer} !== 11'd0) begin
            $display("FAIL reset_outputs got %h expected 0", {power, running, paused, buzzer});
            errors++;
        end
        step();
        checks++;
        if (dut_vec !== exp_vec()) begin
            $display("FAIL reset_idle_vec got %h expected %h", dut_vec, exp_vec());
            errors++;
        end
    endtask

    task automatic test_cook_entry();
        press(1); press(3); press(0);
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== {3'd1, 16'h0130}) begin
            $display("FAIL set_digits got %h expected 10130", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        power_level = 4'd10; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones, power} !== {3'd2, 16'h0130, 8'd250}) begin
            $display("FAIL cook_entry got %h expected 2013 0fa", {state, min_tens, min_ones, sec_tens, sec_ones, power});
            errors++;
        end
        repeat (3) step();
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0130) begin
            $display("FAIL pre_first_tick got %h expected 0130", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        step();
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0129) begin
            $display("FAIL first_tick got %h expected 0129", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        repeat (12) step();
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0126) begin
            $display("FAIL tick16 got %h expected 0126", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
    endtask

    task automatic test_add_pause();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0156) begin
            $display("FAIL add_sec got %h expected 0156", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        step();
        stop = 1'b1;
        step();
        checks++;
        if ({state, power, paused, running} !== {3'd3, 8'd0, 1'b1, 1'b0}) begin
            $display("FAIL pause_entry got %h expected %h", {state, power, paused, running}, {3'd3, 8'd0, 1'b1, 1'b0});
            errors++;
        end
        repeat (5) step();
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== {3'd3, 16'h0156}) begin
            $display("FAIL pause_frozen got %h expected 30156", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        stop = 1'b0;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== 19'd0) begin
            $display("FAIL pause_stop_idle got %h expected 0", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        step();
    endtask

    task automatic test_normalise();
        press(9); press(9);
        checks++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0099) begin
            $display("FAIL set_0099 got %h expected 0099", {min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== {3'd2, 16'h0139}) begin
            $display("FAIL norm_0139 got %h expected 20139", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        stop = 1'b1; step(); stop = 1'b0; step(); stop = 1'b1; step(); stop = 1'b0;
        for (int i = 0; i < 4; i++) press(9);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== {3'd2, 16'h9959}) begin
            $display("FAIL norm_sat got %h expected 29959", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({running, min_tens, min_ones, sec_tens, sec_ones} !== {1'b1, 16'h9959}) begin
            $display("FAIL add_sat got %h expected 19959", {running, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        stop = 1'b1; step(); stop = 1'b0; step(); stop = 1'b1; step(); stop = 1'b0;
        step();
    endtask

    task automatic test_door_done();
        power_level = 4'd4;
        preset_valid = 1'b1; preset_min = 7'd0; preset_sec = 6'd3;
        step();
        preset_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones, power} !== {3'd2, 16'h0003, 8'd100}) begin
            $display("FAIL preset_cook got %h expected 2000364", {state, min_tens, min_ones, sec_tens, sec_ones, power});
            errors++;
        end
        repeat (4) step();
        door_open = 1'b1;
        step();
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones, power, paused} !== {3'd3, 16'h0002, 8'd0, 1'b1}) begin
            $display("FAIL door_pause got %h expected %h", {state, min_tens, min_ones, sec_tens, sec_ones, power, paused},
                     {3'd3, 16'h0002, 8'd0, 1'b1});
            errors++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (state !== 3'd3) begin
            $display("FAIL start_door_open got %0d expected 3", state);
            errors++;
        end
        step();
        door_open = 1'b0;
        step();
        power_level = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, power} !== {3'd2, 8'd100}) begin
            $display("FAIL resume_power got %h expected 264", {state, power});
            errors++;
        end
        for (int k = 0; k < 64 && m_st != 4; k++) begin
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL run_to_done got %h expected %h", dut_vec, exp_vec());
                errors++;
            end
        end
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones} !== {3'd4, 16'h0000}) begin
            $display("FAIL done_reached got %h expected 40000", {state, min_tens, min_ones, sec_tens, sec_ones});
            errors++;
        end
        for (int i = 0; i < 2 * BEEP_CYCLES * BEEP_COUNT; i++) begin
            checks++;
            if ({state, buzzer} !== {3'd4, ((i % 4) < 2) ? 1'b1 : 1'b0}) begin
                $display("FAIL buzz_pattern[%0d] got %h expected %h", i, {state, buzzer}, {3'd4, ((i % 4) < 2) ? 1'b1 : 1'b0});
                errors++;
            end
            step();
        end
        checks++;
        if ({state, buzzer} !== 4'd0) begin
            $display("FAIL done_auto_idle got %h expected 0", {state, buzzer});
            errors++;
        end
    endtask

    task automatic test_quick_async();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, min_tens, min_ones, sec_tens, sec_ones, power} !== {3'd2, 16'h0030, 8'd175}) begin
            $display("FAIL quick_start got %h expected 20030af", {state, min_tens, min_ones, sec_tens, sec_ones, power});
            errors++;
        end
        repeat (2) step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({power, running, buzzer, state} !== 13'd0) begin
            $display("FAIL async_reset got %h expected 0", {power, running, buzzer, state});
            errors++;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        preset_valid = 1'b1; preset_min = 7'd0; preset_sec = 6'd1;
        step();
        preset_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 32 && m_st != 4; k++) step();
        step();
        checks++;
        if ({state, buzzer} !== {3'd4, 1'b1}) begin
            $display("FAIL done_before_door got %h expected 9", {state, buzzer});
            errors++;
        end
        door_open = 1'b1;
        step();
        checks++;
        if ({state, buzzer} !== 4'd0) begin
            $display("FAIL door_in_done got %h expected 0", {state, buzzer});
            errors++;
        end
        door_open = 1'b0;
        step();
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            digit_valid  = (r < 12);
            preset_valid = (r >= 12 && r < 15);
            digit        = 4'($urandom_range(0, 15));
            preset_min   = 7'($urandom_range(0, 99));
            preset_sec   = 6'($urandom_range(0, 59));
            power_level  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) start = ~start;
            if ($urandom_range(0, 14) == 0) stop = ~stop;
            if ($urandom_range(0, 29) == 0) door_open = ~door_open;
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL random[%0d] got %h expected %h", i, dut_vec, exp_vec());
                errors++;
            end
        end
        digit_valid = 1'b0; preset_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cook_entry();
        test_add_pause();
        test_normalise();
        test_door_done();
        test_quick_async();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
